// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : instr_fetch_unit                                                  |
// | Desc   : Fetch stage: PC, req/ack instruction-memory fetch, valid/ready    |
// |          hand-off to decode, redirect with squash of in-flight fetches.    |
// |          Optional perf counters enabled by defining FETCH_PERF_CNT_EN.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter int               AW       = 32,
  parameter int               DW       = 32,
  parameter logic [AW-1:0]    RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic [AW-1:0] pc_plus4,
  output logic [5:0]    op,
  output logic [5:0]    funct
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  localparam logic [AW-1:0] c_word       = AW'(4);
  localparam logic [AW-1:0] c_align_mask = ~AW'(3);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_drain_addr;
  logic [DW-1:0] r_instr;
  logic [AW-1:0] r_instr_pc;
  logic [AW-1:0] w_redir_pc;
  logic          w_accept;

  assign w_redir_pc = redirect_pc & c_align_mask;
  assign w_accept   = (r_state == S_FETCH) && imem_ack && !redirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        // A redirect without ack leaves a request in flight that must be drained.
        if (redirect)      w_state_nxt = imem_ack ? S_FETCH : S_DRAIN;
        else if (imem_ack) w_state_nxt = S_FULL;
      end
      S_FULL:  if (redirect || instr_ready) w_state_nxt = S_FETCH;
      S_DRAIN: if (imem_ack) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc   <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_instr      <= '0;
      r_instr_pc   <= RESET_PC;
    end else begin
      if (redirect)      r_fetch_pc <= w_redir_pc;
      else if (w_accept) r_fetch_pc <= r_fetch_pc + c_word;
      if (w_accept) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_fetch_pc;
      end
      // Keep the outstanding address on the bus while fetch_pc moves to the target.
      if ((r_state == S_FETCH) && redirect && !imem_ack) r_drain_addr <= r_fetch_pc;
    end
  end

  assign imem_req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;
  assign instr_valid = (r_state == S_FULL);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_plus4    = r_instr_pc + c_word;
  assign op          = r_instr[31:26];
  assign funct       = r_instr[5:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = imem_req || (instr_valid && !instr_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (instr_valid && instr_ready && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall && (r_stall_cnt != '1))                    r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Directed table-driven bench for instr_fetch_unit; one vector per clock cycle.
module tb_instr_fetch_unit;

  localparam logic [31:0] A0  = 32'h2001_0005;
  localparam logic [31:0] A1  = 32'h0043_2020;
  localparam logic [31:0] A2  = 32'h1000_0003;
  localparam logic [31:0] B0  = 32'h8C02_0004;
  localparam logic [31:0] C0  = 32'h0800_0010;
  localparam logic [31:0] D0  = 32'h0000_0008;
  localparam logic [31:0] E0  = 32'h2402_FFFF;
  localparam logic [31:0] F0  = 32'hAC03_0008;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [5:0]  op;
  logic [5:0]  funct;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  instr_fetch_unit #(.AW(32), .DW(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .op          (op),
    .funct       (funct)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ack, input logic [31:0] rdata, input logic redir,
                     input logic [31:0] rpc, input logic ready, input logic e_req,
                     input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_ipc, input logic [31:0] e_instr);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.ready = ready;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_ipc = e_ipc; v.e_instr = e_instr;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_fcnt;
    logic [31:0] exp_scnt;
    logic [31:0] ei;
    exp_fcnt = 0;
    exp_scnt = 0;

    //  ack rdata redir rpc         rdy | req addr         vld ipc          instr
    add(0, 0,    0, 0,            1,   0, 0,            0, 0,            0);   // IDLE
    add(1, A0,   0, 0,            1,   1, 0,            0, 0,            0);
    add(1, BAD,  0, 0,            1,   0, 0,            1, 0,            A0);  // stray ack ignored
    add(1, A1,   0, 0,            1,   1, 32'h4,        0, 0,            A0);
    add(0, 0,    0, 0,            1,   0, 0,            1, 32'h4,        A1);
    add(1, A2,   0, 0,            1,   1, 32'h8,        0, 32'h4,        A1);
    add(0, 0,    0, 0,            1,   0, 0,            1, 32'h8,        A2);
    add(0, 0,    0, 0,            1,   1, 32'hC,        0, 32'h8,        A2);  // ack latency 3
    add(0, 0,    0, 0,            1,   1, 32'hC,        0, 32'h8,        A2);
    add(1, B0,   0, 0,            1,   1, 32'hC,        0, 32'h8,        A2);
    for (int i = 0; i < 5; i++)
      add(0, 0,  0, 0,            0,   0, 0,            1, 32'hC,        B0);  // decode stalled
    add(0, 0,    0, 0,            1,   0, 0,            1, 32'hC,        B0);
    add(0, 0,    1, 32'h40,       1,   1, 32'h10,       0, 32'hC,        B0);  // redirect, no ack
    add(0, 0,    0, 0,            1,   1, 32'h10,       0, 32'hC,        B0);  // DRAIN
    add(1, BAD,  0, 0,            1,   1, 32'h10,       0, 32'hC,        B0);
    add(1, C0,   0, 0,            1,   1, 32'h40,       0, 32'hC,        B0);
    add(0, 0,    0, 0,            1,   0, 0,            1, 32'h40,       C0);
    add(1, BAD,  1, 32'h43,       1,   1, 32'h44,       0, 32'h40,       C0);  // redirect + ack
    add(1, D0,   0, 0,            1,   1, 32'h40,       0, 32'h40,       C0);
    add(0, 0,    1, 32'hFFFF_FFFC,1,   0, 0,            1, 32'h40,       D0);  // consume + redirect
    add(1, E0,   0, 0,            1,   1, 32'hFFFF_FFFC,0, 32'h40,       D0);
    add(0, 0,    0, 0,            1,   0, 0,            1, 32'hFFFF_FFFC,E0);
    add(0, 0,    0, 0,            1,   1, 32'h0,        0, 32'hFFFF_FFFC,E0);  // PC wrapped
    add(0, 0,    1, 32'h100,      1,   1, 32'h0,        0, 32'hFFFF_FFFC,E0);
    add(0, 0,    1, 32'h200,      1,   1, 32'h0,        0, 32'hFFFF_FFFC,E0);  // last redirect wins
    add(1, BAD,  0, 0,            1,   1, 32'h0,        0, 32'hFFFF_FFFC,E0);
    add(1, F0,   0, 0,            1,   1, 32'h200,      0, 32'hFFFF_FFFC,E0);
    add(0, 0,    1, 32'h300,      0,   0, 0,            1, 32'h200,      F0);  // redirect in FULL
    add(0, 0,    0, 0,            1,   1, 32'h300,      0, 32'h200,      F0);

    reset_n = 1'b0; imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; instr_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'b0, imem_req}, 0);
    chk("rst_addr",  imem_addr, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ipc",   instr_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fcnt",  fetch_cnt, 0);
    chk("rst_scnt",  stall_cnt, 0);
`endif
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      imem_ack    = vecs[i].ack;
      imem_rdata  = vecs[i].rdata;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      instr_ready = vecs[i].ready;
      ei = vecs[i].e_instr;
      chk($sformatf("v%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_instr", i), instr, ei);
      chk($sformatf("v%0d_ipc", i),   instr_pc, vecs[i].e_ipc);
      chk($sformatf("v%0d_plus4", i), pc_plus4, vecs[i].e_ipc + 32'd4);
      chk($sformatf("v%0d_op", i),    {26'b0, op}, {26'b0, ei[31:26]});
      chk($sformatf("v%0d_funct", i), {26'b0, funct}, {26'b0, ei[5:0]});
      if (vecs[i].e_valid && vecs[i].ready) exp_fcnt++;
      if (vecs[i].e_req || (vecs[i].e_valid && !vecs[i].ready)) exp_scnt++;
    end

    @(negedge clk);
    imem_ack = 0; redirect = 0;
    chk("tail_req",  {31'b0, imem_req}, 1);
    chk("tail_addr", imem_addr, 32'h300);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, exp_fcnt);
    chk("stall_cnt", stall_cnt, exp_scnt);
`endif

    // Asynchronous reset in the middle of a fetch
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req",   {31'b0, imem_req}, 0);
    chk("arst_valid", {31'b0, instr_valid}, 0);
    chk("arst_instr", instr, 0);
    chk("arst_ipc",   instr_pc, 0);
    chk("arst_addr",  imem_addr, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_fcnt",  fetch_cnt, 0);
    chk("arst_scnt",  stall_cnt, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    chk("rel_req0", {31'b0, imem_req}, 0);
    @(negedge clk);
    chk("rel_req1",  {31'b0, imem_req}, 1);
    chk("rel_addr1", imem_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
